// File: rtl/serial_carry_adder_pkg.sv
// serial_carry_adder_pkg: shared FSM state type and default geometry for the serial adder
package serial_carry_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 16;
    localparam int CHUNK_DEF = 4;

endpackage

// File: rtl/serial_carry_adder_carry_chunk.sv
// carry_chunk: combinational W-bit add slice, also exposing the carry into its top bit
module carry_chunk
    import serial_carry_adder_pkg::*;
#(
    parameter int W = CHUNK_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] t;

    always_comb begin
        t        = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        s        = t[W-1:0];
        cout     = t[W];
        // the sum bit is a^b^carry, so the carry entering the top bit falls out of it
        c_msb_in = a[W-1] ^ b[W-1] ^ t[W-1];
    end

endmodule

// File: rtl/serial_carry_adder.sv
// serial_carry_adder: adds/subtracts WIDTH-bit operands CHUNK bits per clock through one shared slice
module serial_carry_adder
    import serial_carry_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 4 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_geometry
        $error("serial_carry_adder: WIDTH must be >= 4 and a multiple of CHUNK");
    end

    state_t            state, state_nx;
    logic [WIDTH-1:0]  a_r, b_r;
    logic              carry;
    logic [IW-1:0]     idx;
    logic [CHUNK-1:0]  s_c;
    logic              co_c, cm_c, last;

    assign last = idx == IW'(N - 1);

    carry_chunk #(.W(CHUNK)) u_chunk (
        .a        (a_r[idx*CHUNK +: CHUNK]),
        .b        (b_r[idx*CHUNK +: CHUNK]),
        .cin      (carry),
        .s        (s_c),
        .cout     (co_c),
        .c_msb_in (cm_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        unique case (state)
            IDLE:    state_nx = in_valid ? BUSY : IDLE;
            BUSY:    state_nx = last ? DONE : BUSY;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // subtraction is folded in at capture: B is stored inverted with a carry-in of 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
        end else if (state == BUSY) begin
            sum[idx*CHUNK +: CHUNK] <= s_c;
            carry <= co_c;
            idx   <= idx + 1'b1;
            if (last) begin
                cout <= co_c;
                ovf  <= cm_c ^ co_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_carry_adder.sv
// tb_serial_carry_adder: directed and random scoreboard bench for serial_carry_adder (WIDTH=16, CHUNK=4)
module tb_serial_carry_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b, sum;
    logic        cin, sub, in_valid, in_ready, cout, ovf, out_valid, out_ready;

    int          tests = 0, failed = 0, cyc = 0, acc_cyc = 0;
    logic [17:0] sb[$];
    bit          prev_ov = 1'b0;

    typedef struct packed {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] s;
        logic        co, ov;
    } vec_t;

    vec_t dv[8] = '{
        '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
        '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
        '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0},
        '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0}
    };

    serial_carry_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic s);
        logic [15:0] yy;
        logic [16:0] r;
        yy = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {16'd0, s | ci};
        return {r[15:0], r[16], (x[15] == yy[15]) && (r[15] != x[15])};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // monitor: latency on each rising out_valid, scoreboard pop on each handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                tests++;
                if (cyc - acc_cyc != 4) begin
                    failed++;
                    $display("FAIL latency: got %0d want 4", cyc - acc_cyc);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    failed++;
                    $display("FAIL unexpected_output: got %h want none", {sum, cout, ovf});
                end else begin
                    logic [17:0] e;
                    e = sb.pop_front();
                    if ({sum, cout, ovf} !== e) begin
                        failed++;
                        $display("FAIL result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 sum, cout, ovf, e[17:2], e[1], e[0]);
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    // called at 1 time unit after a rising edge
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic s,
                         input logic [17:0] exp, input int stall, input bit chk_idle);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_cyc = cyc;
        sb.push_back(exp);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 32'(out_valid), 32'd1);
            return;
        end
        for (int k = 0; k < stall; k++) begin
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_result", 32'({sum, cout, ovf}), 32'(exp));
            check("hold_ready", 32'({in_ready, out_valid}), 32'b01);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (chk_idle) begin
            @(negedge clk);
            check("idle_after_release", 32'({in_ready, out_valid}), 32'b10);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("reset_state", 32'({in_ready, out_valid, sum, cout, ovf}), 32'h80000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (dv[i])
            do_op(dv[i].a, dv[i].b, dv[i].cin, dv[i].sub, {dv[i].s, dv[i].co, dv[i].ov}, 0, 1'b0);

        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1}, 5, 1'b1);

        // reset mid-BUSY: the in-flight operation must vanish
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'({in_ready, out_valid, sum, cout, ovf}), 32'h80000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("no_valid_after_rst", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, {16'h2345, 1'b0, 1'b0}, 0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] x, y;
            logic ci, s;
            x = 16'($urandom); y = 16'($urandom);
            ci = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            do_op(x, y, ci, s, model(x, y, ci, s), int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/serial_carry_adder.md
SERIAL_CARRY_ADDER -- requirements
Module: serial_carry_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits, minimum 4.
REQ-002 Parameter CHUNK, default 4: bits added per clock cycle; CHUNK SHALL divide WIDTH exactly, else elaboration error.
REQ-003 CLK  in  1: single clock; all state SHALL update on its rising edge.
REQ-004 RST_N  in  1: asynchronous, active-low reset.
REQ-005 A  in  WIDTH: operand A.
REQ-006 B  in  WIDTH: operand B.
REQ-007 CIN  in  1: carry-in, used in ADD mode only.
REQ-008 SUB  in  1: 0 = ADD (A+B+CIN); 1 = SUB (A+~B+1, CIN ignored).
REQ-009 IN_VALID  in  1: operands valid.
REQ-010 IN_READY  out  1: block can accept operands.
REQ-011 SUM  out  WIDTH: result.
REQ-012 COUT  out  1: carry out of MSB (in SUB: 1 = no borrow).
REQ-013 OVF  out  1: two's-complement signed overflow.
REQ-014 OUT_VALID  out  1: SUM/COUT/OVF valid.
REQ-015 OUT_READY  in  1: consumer accepts result.

Function
REQ-016 FSM states SHALL be IDLE, BUSY and DONE only.
REQ-017 IDLE: IN_READY=1, OUT_VALID=0; on IN_VALID=1, capture A, B (inverted if SUB), carry (CIN, or 1 if SUB) and SUB; chunk index=0; go to BUSY.
REQ-018 BUSY: each cycle SHALL add chunk i of A and B plus the registered carry, write SUM[i*CHUNK +: CHUNK], register the carry-out and increment i.
REQ-019 BUSY -> DONE after chunk N-1, where N=WIDTH/CHUNK; OUT_VALID SHALL rise exactly N cycles after the accepting edge.
REQ-020 COUT SHALL be the carry out of the last chunk; OVF SHALL be the carry into the MSB XOR the carry out of the MSB.
REQ-021 DONE: OUT_VALID=1, IN_READY=0; SUM, COUT and OVF held stable until OUT_READY=1, then go to IDLE.
REQ-022 IN_READY SHALL be 0 in BUSY and DONE; IN_VALID there SHALL be ignored with no state effect.
REQ-023 Operand changes after acceptance SHALL NOT affect the result in flight.
REQ-024 OUT_READY outside DONE SHALL have no effect.
REQ-025 Throughput: one operation per N+2 cycles with no back-pressure; no overlap of operations.

Reset
REQ-026 RST_N low SHALL immediately force IDLE, IN_READY=1, OUT_VALID=0, SUM=0, COUT=0, OVF=0, chunk index 0 and carry 0.
REQ-027 Reset during BUSY or DONE SHALL discard the operation in flight; no OUT_VALID for it after release.
REQ-028 First acceptance SHALL be possible on the first rising edge after RST_N deasserts.

Structure
REQ-029 Shared package serial_carry_adder_pkg SHALL hold the state enum and the WIDTH/CHUNK default constants.
REQ-030 The combinational CHUNK-bit slice SHALL be a sub-module named carry_chunk (inputs a, b, cin; outputs s, cout, c_msb_in); the top SHALL instance it once.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-031 ADD A=0x0000, B=0x0000, CIN=1 -> SUM=0x0001, COUT=0, OVF=0; OUT_VALID exactly 4 cycles after accept.
REQ-032 ADD A=0xFFFF, B=0x0000, CIN=1 -> carry ripples through all 4 chunks; SUM=0x0000, COUT=1, OVF=0.
REQ-033 SUB A=0x0005, B=0x0007, CIN=0 -> SUM=0xFFFE, COUT=0, OVF=0; ADD A=0x7FFF, B=0x0001, CIN=0 -> SUM=0x8000, COUT=0, OVF=1.
REQ-034 Back-pressure: hold OUT_READY=0 for 5 cycles in DONE, toggling A/B/IN_VALID -> SUM/COUT/OVF stable, IN_READY=0; release -> IDLE next cycle.
REQ-035 Assert RST_N=0 at chunk 2 of BUSY -> outputs at reset values asynchronously; after release no OUT_VALID; next operation (0x1234+0x1111, CIN=0) -> 0x2345.
REQ-036 Random self-check: 1000 random A/B/CIN/SUB operations with random OUT_READY stalls -> every result matches a reference model; no result lost or duplicated.
